// File: rtl/rdma_dma_pkg.sv
// Shared types and field layout for the RDMA DMA scheduler.
// Queue entries carry {tag, len, addr} in their low bits.
package rdma_dma_pkg;

  localparam int ADDR_LSB = 0;
  localparam int LEN_LSB  = 64;
  localparam int TAG_LSB  = 80;
  localparam int ADDR_W   = 64;
  localparam int LEN_W    = 16;
  localparam int TAG_W    = 8;
  localparam int CMD_W    = TAG_LSB + TAG_W;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              dir;
    logic [TAG_W-1:0]  tag;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } dma_cmd_t;

  function automatic dma_cmd_t to_cmd(
    input logic             dir,
    input logic [CMD_W-1:0] e
  );
    dma_cmd_t c;
    c.dir  = dir;
    c.tag  = e[TAG_LSB +: TAG_W];
    c.len  = e[LEN_LSB +: LEN_W];
    c.addr = e[ADDR_LSB +: ADDR_W];
    return c;
  endfunction

endpackage

// File: rtl/rdma_dma_sched_if.sv
// FIFO-side, DMA-command-side and status signals of the scheduler.
// master is the scheduler; slave is the surrounding environment.
interface rdma_dma_sched_if #(
  parameter int DW    = 116,
  parameter int CNT_W = 16
);
  import rdma_dma_pkg::*;

  logic              sqEmpty;
  logic [DW-1:0]     sqData;
  logic              sqPop;
  logic              rqEmpty;
  logic [DW-1:0]     rqData;
  logic              rqPop;
  logic              dmaReqValid;
  logic              dmaReqReady;
  logic              dmaReqDir;
  logic [ADDR_W-1:0] dmaReqAddr;
  logic [LEN_W-1:0]  dmaReqLen;
  logic [TAG_W-1:0]  dmaReqTag;
  logic              rdDmaDone;
  logic              wrDmaDone;
  logic              busy;
  logic              toErr;
  logic              toErrClr;
  logic [CNT_W-1:0]  rdDoneCnt;
  logic [CNT_W-1:0]  wrDoneCnt;

  modport master (
    input  sqEmpty, sqData, rqEmpty, rqData,
    input  dmaReqReady, rdDmaDone, wrDmaDone,
    input  toErrClr,
    output sqPop, rqPop, dmaReqValid, dmaReqDir,
    output dmaReqAddr, dmaReqLen, dmaReqTag,
    output busy, toErr, rdDoneCnt, wrDoneCnt
  );

  modport slave (
    output sqEmpty, sqData, rqEmpty, rqData,
    output dmaReqReady, rdDmaDone, wrDmaDone,
    output toErrClr,
    input  sqPop, rqPop, dmaReqValid, dmaReqDir,
    input  dmaReqAddr, dmaReqLen, dmaReqTag,
    input  busy, toErr, rdDoneCnt, wrDoneCnt
  );

endinterface

// File: rtl/rdma_dma_sched_arb.sv
// Two-way round-robin arbiter; bit 0 is SQ, bit 1 is RQ.
// last=1 means RQ was served last, so SQ wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11) &&  last: gnt = 2'b01;
      (req == 2'b11) && !last: gnt = 2'b10;
      (req == 2'b01):          gnt = 2'b01;
      (req == 2'b10):          gnt = 2'b10;
      default:                 gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/rdma_dma_sched.sv
// Shares one DMA engine between the SQ (read) and RQ (write) queues.
// One command in flight; done/timeout tracking and completion counts.
module rdma_dma_sched
  import rdma_dma_pkg::*;
#(
  parameter int              DW       = 116,
  parameter int              TO_W     = 16,
  parameter logic [TO_W-1:0] TO_LIMIT = 16'hFFFF,
  parameter int              CNT_W    = 16
) (
  input logic               clock,
  input logic               reset,
  rdma_dma_sched_if.master  bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_LIMIT - TO_W'(1);
  localparam bit              TO_EN   = (TO_LIMIT != '0);

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  dma_cmd_t         cmd_q, cmd_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             to_err_q, to_err_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       sq_pop;
  logic       rq_pop;
  logic       done;
  logic       to_hit;
  logic       unused_hi;

  // No grant while reset is held, so no pop can leak out.
  assign req = {~bus.rqEmpty, ~bus.sqEmpty} & {2{reset}};

  rr_arb2 u_arb (
    .req  (req),
    .last (rr_last_q),
    .gnt  (gnt)
  );

  assign done   = cmd_q.dir ? bus.wrDmaDone : bus.rdDmaDone;
  assign to_hit = TO_EN && (to_cnt_q == TO_LAST);

  assign unused_hi = ^{bus.sqData[DW-1:CMD_W],
                       bus.rqData[DW-1:CMD_W]};

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    cmd_d     = cmd_q;
    to_cnt_d  = to_cnt_q;
    to_err_d  = to_err_q & ~bus.toErrClr;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    sq_pop    = 1'b0;
    rq_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt[0]: begin
            sq_pop  = 1'b1;
            cmd_d   = to_cmd(DIR_RD, bus.sqData[CMD_W-1:0]);
            state_d = ISSUE;
          end
          gnt[1]: begin
            rq_pop  = 1'b1;
            cmd_d   = to_cmd(DIR_WR, bus.rqData[CMD_W-1:0]);
            state_d = ISSUE;
          end
          default: ;
        endcase
      end
      ISSUE: begin
        if (bus.dmaReqReady) begin
          state_d   = WAIT_DONE;
          to_cnt_d  = '0;
          rr_last_d = cmd_q.dir;
        end
      end
      WAIT_DONE: begin
        // A done in the timeout cycle still counts as a completion.
        if (done) begin
          state_d = IDLE;
          if (cmd_q.dir == DIR_WR) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
        end else if (to_hit) begin
          state_d  = IDLE;
          to_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      cmd_q     <= '0;
      to_cnt_q  <= '0;
      to_err_q  <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cmd_q     <= cmd_d;
      to_cnt_q  <= to_cnt_d;
      to_err_q  <= to_err_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign bus.sqPop       = sq_pop;
  assign bus.rqPop       = rq_pop;
  assign bus.dmaReqValid = (state_q == ISSUE);
  assign bus.dmaReqDir   = cmd_q.dir;
  assign bus.dmaReqAddr  = cmd_q.addr;
  assign bus.dmaReqLen   = cmd_q.len;
  assign bus.dmaReqTag   = cmd_q.tag;
  assign bus.busy        = (state_q != IDLE);
  assign bus.toErr       = to_err_q;
  assign bus.rdDoneCnt   = rd_cnt_q;
  assign bus.wrDoneCnt   = wr_cnt_q;

endmodule

// File: tb/tb_rdma_dma_sched.sv
// Bench for rdma_dma_sched: queue-backed FIFOs, a round-robin order
// model and per-scenario checks; short timeout and counter widths.
module tb_rdma_dma_sched;
  import rdma_dma_pkg::*;

  localparam int DW    = 116;
  localparam int CNT_W = 4;

  typedef logic [DW-1:0] ent_t;
  typedef logic [CMD_W:0] xfer_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  rdma_dma_sched_if #(.DW(DW), .CNT_W(CNT_W)) sif ();

  rdma_dma_sched #(
    .DW       (DW),
    .TO_W     (16),
    .TO_LIMIT (16'd8),
    .CNT_W    (CNT_W)
  ) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (sif)
  );

  int vectors = 0;
  int errors  = 0;
  int bad_pop = 0;
  int n_pops  = 0;
  int hung    = 0;
  int late    = 0;

  ent_t  sq_q[$];
  ent_t  rq_q[$];
  xfer_t iss_log[$];
  xfer_t exp_q[$];

  logic             m_last = 1'b1;
  logic [CNT_W-1:0] m_rd   = '0;
  logic [CNT_W-1:0] m_wr   = '0;

  function automatic ent_t mk(input logic [63:0] a,
                              input logic [15:0] l,
                              input logic [7:0]  t);
    ent_t e;
    e = '0;
    e[DW-1:CMD_W] = (DW-CMD_W)'($urandom);
    e[63:0]  = a;
    e[79:64] = l;
    e[87:80] = t;
    return e;
  endfunction

  function automatic ent_t mk_rand();
    return mk({$urandom, $urandom}, 16'($urandom), 8'($urandom));
  endfunction

  function automatic xfer_t xf(input logic d, input ent_t e);
    return {d, e[CMD_W-1:0]};
  endfunction

  task automatic drive_fifo();
    sif.sqEmpty = (sq_q.size() == 0);
    sif.sqData  = (sq_q.size() != 0) ? sq_q[0] : '0;
    sif.rqEmpty = (rq_q.size() == 0);
    sif.rqData  = (rq_q.size() != 0) ? rq_q[0] : '0;
  endtask

  // Serve order if everything now queued drains without new arrivals.
  task automatic predict();
    int s = 0;
    int r = 0;
    exp_q.delete();
    while (s < sq_q.size() || r < rq_q.size()) begin
      logic take_rq;
      take_rq = (r < rq_q.size()) && (s >= sq_q.size() || !m_last);
      if (take_rq) begin
        exp_q.push_back(xf(DIR_WR, rq_q[r]));
        r++;
      end else begin
        exp_q.push_back(xf(DIR_RD, sq_q[s]));
        s++;
      end
      m_last = take_rq;
    end
  endtask

  task automatic tick();
    logic ps;
    logic pr;
    @(negedge clock);
    ps = sif.sqPop;
    pr = sif.rqPop;
    if ((ps && sif.sqEmpty) || (pr && sif.rqEmpty) || (ps && pr))
      bad_pop++;
    if (sif.dmaReqValid && sif.dmaReqReady)
      iss_log.push_back({sif.dmaReqDir, sif.dmaReqTag,
                         sif.dmaReqLen, sif.dmaReqAddr});
    n_pops += int'(ps) + int'(pr);
    @(posedge clock);
    #1;
    if (ps && sq_q.size() != 0) void'(sq_q.pop_front());
    if (pr && rq_q.size() != 0) void'(rq_q.pop_front());
    drive_fifo();
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!sif.dmaReqValid && n < 40) begin
      tick();
      n++;
    end
    if (!sif.dmaReqValid) hung++;
  endtask

  task automatic handshake();
    sif.dmaReqReady = 1'b1;
    tick();
    sif.dmaReqReady = 1'b0;
  endtask

  task automatic run_xfers(input int stall, input int dly);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic d;
      d = exp_q[i][CMD_W];
      wait_valid();
      repeat ($urandom_range(stall, 0)) tick();
      handshake();
      repeat ($urandom_range(dly, 0)) begin
        if ($urandom_range(1, 0) == 1) begin
          if (d) sif.rdDmaDone = 1'b1;
          else   sif.wrDmaDone = 1'b1;
        end
        tick();
        sif.rdDmaDone = 1'b0;
        sif.wrDmaDone = 1'b0;
      end
      if (d) sif.wrDmaDone = 1'b1;
      else   sif.rdDmaDone = 1'b1;
      tick();
      sif.rdDmaDone = 1'b0;
      sif.wrDmaDone = 1'b0;
      if (d) m_wr++;
      else   m_rd++;
      if ((sq_q.size() != 0 || rq_q.size() != 0) &&
          !(sif.sqPop || sif.rqPop))
        late++;
    end
  endtask

  task automatic test_reset();
    logic [207:0] got;
    sq_q.push_back(mk_rand());
    drive_fifo();
    #1;
    got = {sif.dmaReqValid, sif.busy, sif.toErr, sif.sqPop,
           sif.rqPop, sif.rdDoneCnt, sif.wrDoneCnt, sif.dmaReqDir,
           sif.dmaReqAddr, sif.dmaReqLen, sif.dmaReqTag};
    vectors++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    sq_q.delete();
    drive_fifo();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (sif.busy !== 1'b0 || sif.sqPop !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy %b pop %b want 0 0",
               sif.busy, sif.sqPop);
    end
  endtask

  task automatic test_sq_only();
    iss_log.delete();
    sq_q.push_back(mk(64'h1000, 16'h40, 8'h05));
    drive_fifo();
    predict();
    sif.dmaReqReady = 1'b1;
    #1;
    vectors++;
    if (sif.sqPop !== 1'b1 || sif.dmaReqValid !== 1'b0) begin
      errors++;
      $display("FAIL sq_pop: pop %b valid %b want 1 0",
               sif.sqPop, sif.dmaReqValid);
    end
    tick();
    vectors++;
    if ({sif.dmaReqValid, sif.dmaReqDir, sif.dmaReqAddr,
         sif.dmaReqLen, sif.dmaReqTag, sif.sqPop} !==
        {1'b1, 1'b0, 64'h1000, 16'h40, 8'h05, 1'b0}) begin
      errors++;
      $display("FAIL sq_issue: v%b d%b a%h l%h t%h p%b want v1 d0 a1000 l40 t05 p0",
               sif.dmaReqValid, sif.dmaReqDir, sif.dmaReqAddr,
               sif.dmaReqLen, sif.dmaReqTag, sif.sqPop);
    end
    tick();
    sif.dmaReqReady = 1'b0;
    vectors++;
    if (sif.busy !== 1'b1 || sif.dmaReqValid !== 1'b0 ||
        iss_log.size() != 1) begin
      errors++;
      $display("FAIL sq_wait: busy %b valid %b issued %0d want 1 0 1",
               sif.busy, sif.dmaReqValid, iss_log.size());
    end
    sif.rdDmaDone = 1'b1;
    tick();
    sif.rdDmaDone = 1'b0;
    m_rd++;
    vectors++;
    if (sif.rdDoneCnt !== m_rd || sif.wrDoneCnt !== m_wr ||
        sif.busy !== 1'b0) begin
      errors++;
      $display("FAIL sq_done: rd %0d wr %0d busy %b want %0d %0d 0",
               sif.rdDoneCnt, sif.wrDoneCnt, sif.busy, m_rd, m_wr);
    end
  endtask

  task automatic test_back_to_back(input int rounds, input int lo,
                                   input int hi, input int stall,
                                   input int dly);
    for (int r = 0; r < rounds; r++) begin
      iss_log.delete();
      repeat ($urandom_range(hi, lo)) sq_q.push_back(mk_rand());
      repeat ($urandom_range(hi, lo)) rq_q.push_back(mk_rand());
      drive_fifo();
      predict();
      run_xfers(stall, dly);
      vectors++;
      if (iss_log.size() != exp_q.size()) begin
        errors++;
        $display("FAIL b2b_count: got %0d want %0d",
                 iss_log.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < iss_log.size(); i++) begin
        vectors++;
        if (iss_log[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_cmd[%0d]: got %h want %h",
                   i, iss_log[i], exp_q[i]);
        end
      end
      vectors++;
      if (sif.rdDoneCnt !== m_rd || sif.wrDoneCnt !== m_wr) begin
        errors++;
        $display("FAIL b2b_cnt: rd %0d wr %0d want %0d %0d",
                 sif.rdDoneCnt, sif.wrDoneCnt, m_rd, m_wr);
      end
    end
  endtask

  task automatic test_stall();
    xfer_t got;
    int p0;
    iss_log.delete();
    sq_q.push_back(mk_rand());
    rq_q.push_back(mk_rand());
    drive_fifo();
    predict();
    p0 = n_pops;
    wait_valid();
    for (int c = 0; c < 10; c++) begin
      tick();
      got = {sif.dmaReqDir, sif.dmaReqTag, sif.dmaReqLen,
             sif.dmaReqAddr};
      vectors++;
      if (sif.dmaReqValid !== 1'b1 || got !== exp_q[0] ||
          n_pops != p0 + 1) begin
        errors++;
        $display("FAIL stall[%0d]: v%b cmd %h pops %0d want v1 %h %0d",
                 c, sif.dmaReqValid, got, n_pops - p0, exp_q[0], 1);
      end
    end
    run_xfers(0, 0);
    vectors++;
    if (iss_log.size() != 2 || iss_log[0] !== exp_q[0] ||
        iss_log[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL stall_order: got %0d cmds want 2 in rr order",
               iss_log.size());
    end
  endtask

  task automatic test_timeout();
    sq_q.push_back(mk_rand());
    drive_fifo();
    predict();
    wait_valid();
    handshake();
    repeat (7) tick();
    vectors++;
    if (sif.toErr !== 1'b0 || sif.busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early: toErr %b busy %b want 0 1",
               sif.toErr, sif.busy);
    end
    tick();
    vectors++;
    if (sif.toErr !== 1'b1 || sif.busy !== 1'b0 ||
        sif.rdDoneCnt !== m_rd || sif.wrDoneCnt !== m_wr) begin
      errors++;
      $display("FAIL to_fire: toErr %b busy %b rd %0d wr %0d want 1 0 %0d %0d",
               sif.toErr, sif.busy, sif.rdDoneCnt, sif.wrDoneCnt,
               m_rd, m_wr);
    end
    repeat (3) tick();
    vectors++;
    if (sif.toErr !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: got %b want 1", sif.toErr);
    end
    sif.toErrClr = 1'b1;
    tick();
    sif.toErrClr = 1'b0;
    vectors++;
    if (sif.toErr !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: got %b want 0", sif.toErr);
    end
    rq_q.push_back(mk_rand());
    drive_fifo();
    predict();
    wait_valid();
    handshake();
    repeat (7) tick();
    sif.toErrClr = 1'b1;
    tick();
    sif.toErrClr = 1'b0;
    vectors++;
    if (sif.toErr !== 1'b1 || sif.wrDoneCnt !== m_wr) begin
      errors++;
      $display("FAIL to_set_wins: toErr %b wr %0d want 1 %0d",
               sif.toErr, sif.wrDoneCnt, m_wr);
    end
    sif.toErrClr = 1'b1;
    tick();
    sif.toErrClr = 1'b0;
  endtask

  task automatic test_done_filter();
    sq_q.push_back(mk_rand());
    drive_fifo();
    predict();
    wait_valid();
    handshake();
    sif.wrDmaDone = 1'b1;
    tick();
    sif.wrDmaDone = 1'b0;
    vectors++;
    if (sif.busy !== 1'b1 || sif.wrDoneCnt !== m_wr) begin
      errors++;
      $display("FAIL wrong_done: busy %b wr %0d want 1 %0d",
               sif.busy, sif.wrDoneCnt, m_wr);
    end
    repeat (6) tick();
    sif.rdDmaDone = 1'b1;
    tick();
    sif.rdDmaDone = 1'b0;
    m_rd++;
    vectors++;
    if (sif.rdDoneCnt !== m_rd || sif.toErr !== 1'b0 ||
        sif.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_vs_to: rd %0d toErr %b busy %b want %0d 0 0",
               sif.rdDoneCnt, sif.toErr, sif.busy, m_rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [207:0] got;
    sq_q.push_back(mk_rand());
    sq_q.push_back(mk_rand());
    drive_fifo();
    predict();
    wait_valid();
    handshake();
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    got = {sif.dmaReqValid, sif.busy, sif.toErr, sif.sqPop,
           sif.rqPop, sif.rdDoneCnt, sif.wrDoneCnt, sif.dmaReqDir,
           sif.dmaReqAddr, sif.dmaReqLen, sif.dmaReqTag};
    vectors++;
    if (got !== '0) begin
      errors++;
      $display("FAIL mid_reset: got %h want 0", got);
    end
    m_rd   = '0;
    m_wr   = '0;
    m_last = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    iss_log.delete();
    predict();
    run_xfers(1, 2);
    vectors++;
    if (iss_log.size() != 1 || iss_log[0] !== exp_q[0] ||
        sif.rdDoneCnt !== m_rd) begin
      errors++;
      $display("FAIL post_reset: issued %0d rd %0d want 1 %0d",
               iss_log.size(), sif.rdDoneCnt, m_rd);
    end
  endtask

  task automatic test_protocol();
    vectors++;
    if (bad_pop != 0 || hung != 0 || late != 0) begin
      errors++;
      $display("FAIL protocol: bad_pop %0d hung %0d late %0d want 0 0 0",
               bad_pop, hung, late);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal;
  end

  initial begin
    sif.dmaReqReady = 1'b0;
    sif.rdDmaDone   = 1'b0;
    sif.wrDmaDone   = 1'b0;
    sif.toErrClr    = 1'b0;
    drive_fifo();
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_sq_only();
    test_back_to_back(1, 3, 3, 0, 0);
    test_stall();
    test_timeout();
    test_done_filter();
    test_reset_mid();
    test_back_to_back(8, 2, 4, 3, 6);
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
